stop_watch: RTL and testbench
=============================

STOP_WATCH -- requirements
Module: stop_watch

Interface
REQ-001 Parameter: CYCLES_PER_MS, default 50000, number of clk cycles per elapsed millisecond; legal range 1 to 2^24.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous, active-low (rst=0 resets, rst=1 runs).
REQ-004 Port: nrms  output  32  elapsed milliseconds since reset release, unsigned binary, registered.

Function
REQ-005 The block SHALL contain a prescaler register sized to hold 0..CYCLES_PER_MS-1 (minimum width 1 bit).
REQ-006 While rst=1, the prescaler SHALL increment by 1 on each rising clk edge.
REQ-007 When the prescaler equals CYCLES_PER_MS-1 at a rising edge, on that same edge:
  - the prescaler SHALL return to 0;
  - an internal one-cycle ms tick SHALL be asserted.
REQ-008 On each ms tick edge, nrms SHALL increment by 1, so there is no added latency between tick and count.
REQ-009 After rst rises, the first nrms increment SHALL occur on the CYCLES_PER_MS-th rising clk edge, and subsequent increments every CYCLES_PER_MS edges exactly; there is no drift.
REQ-010 With CYCLES_PER_MS=1, nrms SHALL increment on every rising edge after reset release.
REQ-011 nrms SHALL be driven directly from a register, with no combinational path from rst (other than the async clear) or from clk.
REQ-012 nrms SHALL hold its value between ticks; there is no start, stop or pause control.
REQ-013 Wrap-around behaviour SHALL be as defined under Configuration; the counter SHALL never skip or repeat a value except at the defined wrap point.

Reset
REQ-014 When rst=0, nrms and the prescaler SHALL clear to 0 immediately, without waiting for a clk edge.
REQ-015 Reset asserted mid-count SHALL discard any partial millisecond; counting SHALL restart per REQ-009 after release.
REQ-016 While rst=0, all outputs SHALL hold 0 regardless of clk activity.
REQ-017 Reset release SHALL be treated as synchronous to clk; the first counting edge is the first rising edge with rst=1.

Configuration
REQ-018 Macro STOP_WATCH_DAY_WRAP_EN defined:
  - nrms SHALL count 0..86_399_999 (one day);
  - on the tick at 86_399_999, nrms SHALL become 0.
REQ-019 Macro STOP_WATCH_DAY_WRAP_EN undefined: nrms SHALL count modulo 2^32, wrapping from 32'hFFFF_FFFF to 0.
REQ-020 The prescaler behaviour SHALL be identical with and without the macro.

Verification
REQ-021 CYCLES_PER_MS=4; hold rst=0 for 2 clk cycles, then release -> nrms=0 during reset; nrms=1 after the 4th rising edge; nrms=5 after the 20th.
REQ-022 CYCLES_PER_MS=4; run to nrms=3 plus 2 extra edges, then pull rst=0 between edges -> nrms=0 immediately; after release, nrms=1 only after 4 further edges.
REQ-023 CYCLES_PER_MS=1 -> nrms equals the number of rising edges since release (1, 2, 3, ...).
REQ-024 Macro defined, CYCLES_PER_MS=1, nrms forced or preloaded to 86_399_998 -> next edges give 86_399_999, then 0, then 1.
REQ-025 Macro undefined, CYCLES_PER_MS=1, nrms preloaded to 32'hFFFF_FFFE -> next edges give FFFF_FFFF, then 0.
REQ-026 Default CYCLES_PER_MS=50000 with 200 ns clk period -> nrms=1 at 10 ms after reset release, and nrms=10 at 100 ms.

Source files
------------

// File: rtl/stop_watch.sv
// stop_watch: free-running millisecond counter.
// A prescaler divides clk by CYCLES_PER_MS to produce a one-cycle ms tick,
// and nrms counts those ticks from reset release.
// Optional build macro STOP_WATCH_DAY_WRAP_EN: when defined, nrms wraps after
// one day (0..86_399_999); otherwise nrms wraps modulo 2^32.
module stop_watch #(
  parameter int CYCLES_PER_MS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] nrms
);

  // Prescaler must hold 0..CYCLES_PER_MS-1; keep at least one bit so the
  // CYCLES_PER_MS=1 case still has a legal (constant-zero) register.
  localparam int PW = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MS - 1);

`ifdef STOP_WATCH_DAY_WRAP_EN
  localparam logic [31:0] NRMS_LAST = 32'd86_399_999;
`endif

  logic [PW-1:0] presc_q;
  logic [31:0]   nrms_q;
  logic [31:0]   nrms_next;
  logic          ms_tick;

  // The tick is asserted during the cycle whose closing edge completes a
  // millisecond, so nrms updates on that very edge with no extra latency.
  always_comb begin
    ms_tick = (presc_q == PRESC_LAST);
  end

  // Next millisecond value, including the configured wrap point.
  always_comb begin
    nrms_next = nrms_q + 32'd1;
`ifdef STOP_WATCH_DAY_WRAP_EN
    if (nrms_q >= NRMS_LAST) begin
      nrms_next = 32'd0;
    end
`endif
  end

  // Prescaler: counts clk edges within the current millisecond; a reset
  // discards any partial millisecond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (ms_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  // Millisecond counter: advances only on the tick edge, holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nrms_q <= 32'd0;
    end else if (ms_tick) begin
      nrms_q <= nrms_next;
    end
  end

  assign nrms = nrms_q;

endmodule

// File: tb/tb_stop_watch.sv
// tb_stop_watch: directed checks of stop_watch with three parameterisations
// (CYCLES_PER_MS = 4, 1 and the default 50000 on a 200 ns clock).
module tb_stop_watch;

  // ---------------- clock / reset ----------------
  logic clk;
  logic clk_d;
  logic run_fast;
  logic run_slow;
  logic rst_c4;
  logic rst_c1;
  logic rst_d;
  logic [31:0] nrms_c4;
  logic [31:0] nrms_c1;
  logic [31:0] nrms_d;

  int checks;
  int failures;

  initial begin
    clk      = 1'b0;
    clk_d    = 1'b0;
    run_fast = 1'b1;
    run_slow = 1'b0;
  end

  // 10 ns clock for the small-divider instances, gated off for the long run.
  always begin
    wait (run_fast);
    #5 clk = ~clk;
  end

  // 200 ns clock for the default-parameter instance, only during its test.
  always begin
    wait (run_slow);
    #100 clk_d = ~clk_d;
  end

  stop_watch #(.CYCLES_PER_MS(4)) u_c4 (
    .clk  (clk),
    .rst  (rst_c4),
    .nrms (nrms_c4)
  );

  stop_watch #(.CYCLES_PER_MS(1)) u_c1 (
    .clk  (clk),
    .rst  (rst_c1),
    .nrms (nrms_c1)
  );

  stop_watch u_def (
    .clk  (clk_d),
    .rst  (rst_d),
    .nrms (nrms_d)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)",
             tag, obs, obs, exp, exp);
    end
  endtask

`ifdef STOP_WATCH_DAY_WRAP_EN
  localparam logic [31:0] PRELOAD = 32'd86_399_998;
  localparam logic [31:0] WRAP_1  = 32'd86_399_999;
`else
  localparam logic [31:0] PRELOAD = 32'hFFFF_FFFE;
  localparam logic [31:0] WRAP_1  = 32'hFFFF_FFFF;
`endif

  // ---------------- directed sequence ----------------
  initial begin
    checks   = 0;
    failures = 0;
    rst_c4   = 1'b0;
    rst_c1   = 1'b0;
    rst_d    = 1'b0;

    // Reset held for two edges: outputs stay zero despite clock activity.
    #1;
    check("reset_c4_t0", nrms_c4, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_c4_2edges", nrms_c4, 32'd0);
    check("reset_c1_2edges", nrms_c1, 32'd0);

    // Release between edges; first counting edge is the next rising edge.
    @(negedge clk);
    rst_c4 = 1'b1;
    rst_c1 = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("c4_edge%0d", e), nrms_c4, 32'(e / 4));
      check($sformatf("c1_edge%0d", e), nrms_c1, 32'(e));
    end

    // Async reset mid-cycle clears immediately.
    @(negedge clk);
    rst_c4 = 1'b0;
    #1;
    check("c4_async_clear_from5", nrms_c4, 32'd0);
    @(negedge clk);
    rst_c4 = 1'b1;

    // Run to nrms=3 (12 edges) plus 2 extra edges, then reset between edges.
    repeat (14) @(posedge clk);
    #1;
    check("c4_at_14_edges", nrms_c4, 32'd3);
    #2;
    rst_c4 = 1'b0;
    #1;
    check("c4_mid_reset_immediate", nrms_c4, 32'd0);
    @(posedge clk);
    #1;
    check("c4_held_in_reset", nrms_c4, 32'd0);
    @(negedge clk);
    rst_c4 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      check($sformatf("c4_restart_edge%0d", e), nrms_c4, (e == 4) ? 32'd1 : 32'd0);
    end

    // Wrap point: preload the c1 counter just below the wrap value.
    @(negedge clk);
    force u_c1.nrms_q = PRELOAD;
    #1;
    check("c1_preload", nrms_c1, PRELOAD);
    release u_c1.nrms_q;
    @(posedge clk);
    #1;
    check("c1_wrap_last", nrms_c1, WRAP_1);
    @(posedge clk);
    #1;
    check("c1_wrap_zero", nrms_c1, 32'd0);
    @(posedge clk);
    #1;
    check("c1_wrap_one", nrms_c1, 32'd1);

    // Default divider on a 200 ns clock: nrms=1 exactly 10 ms after release.
    @(negedge clk);
    run_fast = 1'b0;
    run_slow = 1'b1;
    repeat (2) @(posedge clk_d);
    #1;
    check("def_reset", nrms_d, 32'd0);
    @(negedge clk_d);
    rst_d = 1'b1;
    repeat (49999) @(posedge clk_d);
    #1;
    check("def_edge49999", nrms_d, 32'd0);
    @(posedge clk_d);
    #1;
    check("def_edge50000_10ms", nrms_d, 32'd1);
    repeat (10) @(posedge clk_d);
    #1;
    check("def_holds_between_ticks", nrms_d, 32'd1);
    run_slow = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
